// File: rtl/fsmc_reg_bridge_pkg.sv
// Shared register map, bit positions and FSM state type for the FSMC register bridge.
package fsmc_pkg;

  localparam logic [3:0] REG_CTRL   = 4'd1;
  localparam logic [3:0] REG_TXD    = 4'd2;
  localparam logic [3:0] REG_RXD    = 4'd3;
  localparam logic [3:0] REG_STATUS = 4'd4;

  localparam int CTRL_ENABLE   = 0;
  localparam int CTRL_TX_FLUSH = 1;
  localparam int CTRL_RX_FLUSH = 2;

  localparam int STAT_TX_OVF     = 15;
  localparam int STAT_RX_UNF     = 14;
  localparam int STAT_TX_FULL    = 13;
  localparam int STAT_RX_EMPTY   = 12;
  localparam int STAT_RX_LVL_LSB = 6;
  localparam int STAT_TX_LVL_LSB = 0;
  localparam int STAT_LVL_W      = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    COMMIT = 2'd2
  } bridge_state_t;

endpackage

// File: rtl/fsmc_reg_bridge_sync_fifo.sv
// Show-ahead synchronous FIFO with flush; head reads 0 while empty.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign level   = count;
  assign pop_ok  = pop & ~empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is accepted then.
  assign push_ok = push & (~full | pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fsmc_reg_bridge.sv
// Register/FIFO bridge behind fsmc_interface: CTRL, STATUS, TX FIFO (MCU->stream), RX FIFO (stream->MCU).
module fsmc_reg_bridge
  import fsmc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cs,
  input  logic          state,
  input  logic [DW-1:0] rx_word,
  output logic [DW-1:0] tx_word,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          enable,
  output bridge_state_t dbg_state
);
  localparam int LW = $clog2(DEPTH) + 1;

  bridge_state_t fsm;
  logic [3:0]    cs_q;
  logic          state_q;
  logic [DW-1:0] word_q;
  logic          enable_q;
  logic          tx_ovf;
  logic          rx_unf;
  logic [DW-1:0] tx_word_q;
  logic [DW-1:0] rdata;
  logic [DW-1:0] status_word;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [LW-1:0] tx_level, rx_level;
  logic [DW-1:0] tx_head, rx_head;

  // Access FSM: the latched select/direction/word is acted on in the single COMMIT cycle
  // that follows the falling edge of cs, so long accesses still commit exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm     <= IDLE;
      cs_q    <= '0;
      state_q <= 1'b0;
      word_q  <= '0;
    end else begin
      case (fsm)
        ACCESS: begin
          if (cs != 4'd0) begin
            cs_q    <= cs;
            state_q <= state;
            word_q  <= rx_word;
          end else begin
            fsm <= COMMIT;
          end
        end
        IDLE, COMMIT: begin
          if (cs != 4'd0) begin
            fsm     <= ACCESS;
            cs_q    <= cs;
            state_q <= state;
            word_q  <= rx_word;
          end else begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  logic commit, ctrl_wr, txd_wr, rxd_rd, stat_rd;
  logic tx_push, tx_pop, tx_flush, rx_push, rx_pop, rx_flush;

  assign commit   = (fsm == COMMIT);
  assign ctrl_wr  = commit &  state_q & (cs_q == REG_CTRL);
  assign txd_wr   = commit &  state_q & (cs_q == REG_TXD);
  assign rxd_rd   = commit & ~state_q & (cs_q == REG_RXD);
  assign stat_rd  = commit & ~state_q & (cs_q == REG_STATUS);

  assign tx_flush = ctrl_wr & word_q[CTRL_TX_FLUSH];
  assign rx_flush = ctrl_wr & word_q[CTRL_RX_FLUSH];
  assign tx_push  = txd_wr & ~tx_full;
  assign rx_pop   = rxd_rd & ~rx_empty;

  // Streams use valid/ready: a beat transfers on any cycle where both are high;
  // valid never depends on ready, and both sides are held off while disabled.
  assign m_valid  = enable_q & ~tx_empty;
  assign s_ready  = enable_q & ~rx_full;
  assign tx_pop   = m_valid & m_ready;
  assign rx_push  = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_unf   <= 1'b0;
    end else begin
      if (ctrl_wr) enable_q <= word_q[CTRL_ENABLE];
      if (txd_wr && tx_full) tx_ovf <= 1'b1;
      else if (stat_rd)      tx_ovf <= 1'b0;
      if (rxd_rd && rx_empty) rx_unf <= 1'b1;
      else if (stat_rd)       rx_unf <= 1'b0;
    end
  end

  always_comb begin
    status_word = '0;
    status_word[STAT_TX_OVF]   = tx_ovf;
    status_word[STAT_RX_UNF]   = rx_unf;
    status_word[STAT_TX_FULL]  = tx_full;
    status_word[STAT_RX_EMPTY] = rx_empty;
    status_word[STAT_RX_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(rx_level);
    status_word[STAT_TX_LVL_LSB +: STAT_LVL_W] = STAT_LVL_W'(tx_level);
  end

  // Read data follows the live select so it is stable through the MCU read window.
  always_comb begin
    rdata = '0;
    case (cs)
      REG_CTRL:   rdata[CTRL_ENABLE] = enable_q;
      REG_RXD:    rdata = rx_head;
      REG_STATUS: rdata = status_word;
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) tx_word_q <= '0;
    else       tx_word_q <= rdata;
  end

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (tx_flush),
    .din   (word_q),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_level)
  );

  sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (rx_flush),
    .din   (s_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign tx_word   = tx_word_q;
  assign m_data    = tx_head;
  assign enable    = enable_q;
  assign dbg_state = fsm;

endmodule

// File: tb/tb_fsmc_reg_bridge.sv
// Directed bench for fsmc_reg_bridge: register access table plus stream, overflow, flush and reset sequences.
module tb_fsmc_reg_bridge;
  import fsmc_pkg::*;

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    cs;
  logic          state;
  logic [15:0]   rx_word;
  logic [15:0]   tx_word;
  logic [15:0]   m_data;
  logic          m_valid;
  logic          m_ready;
  logic [15:0]   s_data;
  logic          s_valid;
  logic          s_ready;
  logic          enable;
  bridge_state_t dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0]  sel;
    logic        dir;
    logic [15:0] wd;
    logic        do_chk;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  fsmc_reg_bridge #(.DEPTH(16), .DW(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .state     (state),
    .rx_word   (rx_word),
    .tx_word   (tx_word),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .enable    (enable),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] sel, input logic dir, input logic [15:0] wd,
                              input logic do_chk, input logic [15:0] exp, input string name);
    vec_t v;
    v.sel = sel; v.dir = dir; v.wd = wd; v.do_chk = do_chk; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Driver: called at posedge+1; holds cs for 4 edges, samples tx_word, then waits out the commit.
  task automatic access(input logic [3:0] sel, input logic dir, input logic [15:0] wd,
                        output logic [15:0] rd);
    cs = sel; state = dir; rx_word = wd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rd = tx_word;
    @(posedge clk); #1;
    cs = 4'd0; state = 1'b0; rx_word = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_wr(input logic [3:0] sel, input logic [15:0] wd);
    logic [15:0] rd;
    access(sel, 1'b1, wd, rd);
  endtask

  task automatic do_rd(input logic [3:0] sel, input logic [15:0] exp, input string name);
    logic [15:0] rd;
    access(sel, 1'b0, 16'h0000, rd);
    chk(name, rd, exp);
  endtask

  task automatic rx_send(input logic [15:0] d);
    s_data = d; s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 16'h0000;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_word"}, tx_word, 16'h0000);
    chk({tag, "_m_data"},  m_data,  16'h0000);
    chk({tag, "_m_valid"}, {15'd0, m_valid}, 16'h0000);
    chk({tag, "_s_ready"}, {15'd0, s_ready}, 16'h0000);
    chk({tag, "_enable"},  {15'd0, enable},  16'h0000);
    chk({tag, "_fsm"},     {14'd0, dbg_state}, 16'h0000);
  endtask

  initial begin
    logic [15:0] rd;
    reset = 1'b1; cs = 4'd0; state = 1'b0; rx_word = 16'h0000;
    m_ready = 1'b0; s_data = 16'h0000; s_valid = 1'b0;

    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Register access table
    vecs.push_back(mk(4'd1, 1'b1, 16'h0001, 1'b0, 16'h0000, "wr_ctrl"));
    vecs.push_back(mk(4'd1, 1'b0, 16'h0000, 1'b1, 16'h0001, "rd_ctrl"));
    vecs.push_back(mk(4'd2, 1'b1, 16'h0F0F, 1'b0, 16'h0000, "wr_txd0"));
    vecs.push_back(mk(4'd2, 1'b1, 16'h1234, 1'b0, 16'h0000, "wr_txd1"));
    vecs.push_back(mk(4'd4, 1'b0, 16'h0000, 1'b1, 16'h1002, "rd_status_lvl2"));
    vecs.push_back(mk(4'd2, 1'b0, 16'h0000, 1'b1, 16'h0000, "rd_txd_zero"));
    vecs.push_back(mk(4'd5, 1'b0, 16'h0000, 1'b1, 16'h0000, "rd_unmapped"));
    vecs.push_back(mk(4'd4, 1'b1, 16'hFFFF, 1'b0, 16'h0000, "wr_status_ignored"));
    vecs.push_back(mk(4'd3, 1'b1, 16'hBEEF, 1'b0, 16'h0000, "wr_rxd_ignored"));
    vecs.push_back(mk(4'd6, 1'b1, 16'h0006, 1'b0, 16'h0000, "wr_unmapped"));
    vecs.push_back(mk(4'd4, 1'b0, 16'h0000, 1'b1, 16'h1002, "rd_status_same"));
    vecs.push_back(mk(4'd3, 1'b0, 16'h0000, 1'b1, 16'h0000, "rd_rxd_empty"));
    vecs.push_back(mk(4'd4, 1'b0, 16'h0000, 1'b1, 16'h5002, "rd_status_unf"));
    vecs.push_back(mk(4'd4, 1'b0, 16'h0000, 1'b1, 16'h1002, "rd_status_clr"));

    foreach (vecs[i]) begin
      access(vecs[i].sel, vecs[i].dir, vecs[i].wd, rd);
      if (vecs[i].do_chk) chk(vecs[i].name, rd, vecs[i].exp);
    end

    chk("enable_set", {15'd0, enable}, 16'h0001);
    @(negedge clk);
    chk("m_valid_held", {15'd0, m_valid}, 16'h0001);
    chk("m_data_head",  m_data, 16'h0F0F);

    // TX stream drain
    @(posedge clk); #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("drain0", m_data, 16'h0F0F);
    @(negedge clk);
    chk("drain1", m_data, 16'h1234);
    @(negedge clk);
    chk("drain_done_valid", {15'd0, m_valid}, 16'h0000);
    chk("drain_done_data",  m_data, 16'h0000);
    @(posedge clk); #1;
    m_ready = 1'b0;

    // TX overflow: 17th word dropped, level stays 16
    for (int i = 0; i < 17; i++) do_wr(4'd2, 16'h0100 + 16'(i));
    do_rd(4'd4, 16'hB010, "status_ovf");
    do_rd(4'd4, 16'h3010, "status_ovf_clr");
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("ovf_drain%0d", i), m_data, 16'h0100 + 16'(i));
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("ovf_drain_empty", {15'd0, m_valid}, 16'h0000);
    @(posedge clk); #1;
    m_ready = 1'b0;
    do_rd(4'd4, 16'h1000, "status_after_drain");

    // RX path and underflow
    s_data = 16'h2321; s_valid = 1'b1;
    @(negedge clk);
    chk("s_ready_enabled", {15'd0, s_ready}, 16'h0001);
    @(posedge clk); #1;
    s_valid = 1'b0; s_data = 16'h0000;
    do_rd(4'd4, 16'h0040, "status_rx1");
    do_rd(4'd3, 16'h2321, "rd_rxd");
    do_rd(4'd4, 16'h1000, "status_rx0");
    do_rd(4'd3, 16'h0000, "rd_rxd_unf");
    do_rd(4'd4, 16'h5000, "status_unf");
    do_rd(4'd4, 16'h1000, "status_unf_clr");

    // Flush both FIFOs at level 3
    for (int i = 0; i < 3; i++) do_wr(4'd2, 16'hA000 + 16'(i));
    for (int i = 0; i < 3; i++) rx_send(16'hC000 + 16'(i));
    do_rd(4'd4, 16'h00C3, "status_lvl3");
    do_wr(4'd1, 16'h0007);
    do_rd(4'd4, 16'h1000, "status_flushed");
    do_rd(4'd1, 16'h0001, "ctrl_selfclear");
    @(negedge clk);
    chk("flush_m_valid", {15'd0, m_valid}, 16'h0000);
    @(posedge clk); #1;

    // Reset during a TXD write: access abandoned
    cs = 4'd2; state = 1'b1; rx_word = 16'h5A5A;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    cs = 4'd0; state = 1'b0; rx_word = 16'h0000;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #1;
    do_wr(4'd1, 16'h0001);
    do_rd(4'd4, 16'h1000, "status_no_push");
    @(negedge clk);
    chk("midreset_m_valid", {15'd0, m_valid}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
